// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state encoding and lamp types for the intersection controller
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G = 3'd0,
    NS_Y = 3'd1,
    AR1  = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    AR2  = 3'd5,
    WALK = 3'd6
  } ctrl_state_t;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable phase down-counter that saturates at zero
module phase_timer #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// rtl/intersection_ctrl.sv - two-way intersection sequencer with all-red clearance and pedestrian walk
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned WALK_CYC   = 6,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       ns_red,
  output logic       ns_yellow,
  output logic       ns_green,
  output logic       ew_red,
  output logic       ew_yellow,
  output logic       ew_green,
  output logic       walk,
  output logic [2:0] state_o
);

  ctrl_state_t      state_q, state_d;
  logic             ped_pend_q, ped_pend_d;
  logic             next_dir_q, next_dir_d;
  logic             ped_ack_q;
  logic             tmr_zero, expired, load, entering_walk;
  logic [CNT_W-1:0] load_val;
  lamp_t            ns_lamp, ew_lamp;

  assign expired = tmr_zero & en;

  always_comb begin
    state_d = state_q;
    case (state_q)
      NS_G:    if (expired && (car_ew || ped_pend_q)) state_d = NS_Y;
      NS_Y:    if (expired) state_d = AR1;
      AR1:     if (expired) state_d = ped_pend_q ? WALK : EW_G;
      EW_G:    if (expired && (car_ns || ped_pend_q)) state_d = EW_Y;
      EW_Y:    if (expired) state_d = AR2;
      AR2:     if (expired) state_d = ped_pend_q ? WALK : NS_G;
      WALK:    if (expired) state_d = next_dir_q ? EW_G : NS_G;
      default: state_d = NS_G;
    endcase
  end

  // Timer reloads only on a real state change, so a held green sits at zero and re-checks each cycle.
  assign load = (state_d != state_q);

  always_comb begin
    load_val = CNT_W'(GREEN_CYC - 1);
    case (state_d)
      NS_Y, EW_Y: load_val = CNT_W'(YELLOW_CYC - 1);
      AR1, AR2:   load_val = CNT_W'(ALLRED_CYC - 1);
      WALK:       load_val = CNT_W'(WALK_CYC - 1);
      default:    load_val = CNT_W'(GREEN_CYC - 1);
    endcase
  end

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(GREEN_CYC - 1)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .en      (en),
    .zero    (tmr_zero)
  );

  assign entering_walk = (state_d == WALK) && (state_q != WALK);
  // A request arriving on the entry edge survives the clear and is served next round.
  assign ped_pend_d    = (entering_walk ? 1'b0 : ped_pend_q) | ped_req;
  assign next_dir_d    = entering_walk ? (state_q == AR1) : next_dir_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NS_G;
      ped_pend_q <= 1'b0;
      next_dir_q <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      next_dir_q <= next_dir_d;
      ped_ack_q  <= entering_walk;
    end
  end

  always_comb begin
    ns_lamp = LAMP_RED;
    ew_lamp = LAMP_RED;
    walk    = 1'b0;
    case (state_q)
      NS_G:    ns_lamp = LAMP_GREEN;
      NS_Y:    ns_lamp = LAMP_YELLOW;
      EW_G:    ew_lamp = LAMP_GREEN;
      EW_Y:    ew_lamp = LAMP_YELLOW;
      WALK:    walk    = 1'b1;
      default: begin
        ns_lamp = LAMP_RED;
        ew_lamp = LAMP_RED;
      end
    endcase
  end

  assign ns_red    = ns_lamp.red;
  assign ns_yellow = ns_lamp.yellow;
  assign ns_green  = ns_lamp.green;
  assign ew_red    = ew_lamp.red;
  assign ew_yellow = ew_lamp.yellow;
  assign ew_green  = ew_lamp.green;
  assign ped_ack   = ped_ack_q;
  assign state_o   = state_q;

endmodule
